// File: rtl/fft16_frame_capture.sv
// Captures one RDY-framed complex result frame from fft16 into a small buffer and
// replays it on request as a START-framed stream, scaled back to the fft16 input width.
module fft16_frame_capture #(
  parameter int NPT    = 16,
  parameter int LOGN   = 4,
  parameter int IW     = 36,
  parameter int OW     = 32,
  parameter int SHIFT  = 4,
  parameter int BITREV = 0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ED,
  input  logic          RDY,
  input  logic [IW-1:0] DIReal,
  input  logic [IW-1:0] DIImag,
  input  logic          RD_REQ,
  output logic          FULL,
  output logic          START,
  output logic          VALID,
  output logic [OW-1:0] DOReal,
  output logic [OW-1:0] DOImag,
  output logic          OVR
);

  // One spare bit beyond the wider of IW/OW keeps the saturation compare signed-safe.
  localparam int WW = ((IW > OW) ? IW : OW) + 1;
  localparam logic [LOGN-1:0] LAST = LOGN'(NPT - 1);
  localparam logic signed [WW-1:0] SAT_MAX = {{(WW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [WW-1:0] SAT_MIN = {{(WW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPT,
    S_FULL,
    S_PLAY
  } state_t;

  state_t          state_q, state_d;
  logic [LOGN-1:0] index_q, index_d;
  logic            ovr_q, ovr_d;
  logic            start_q, start_d;
  logic            valid_q, valid_d;
  logic [OW-1:0]   dore_q, dore_d;
  logic [OW-1:0]   doim_q, doim_d;

  logic signed [IW-1:0] mem_re_q [NPT];
  logic signed [IW-1:0] mem_im_q [NPT];

  logic            we_d;
  logic [LOGN-1:0] waddr_d;
  logic [LOGN-1:0] raddr_d;
  logic [LOGN-1:0] cap_addr;

  function automatic logic [LOGN-1:0] bit_reverse(input logic [LOGN-1:0] a);
    logic [LOGN-1:0] r;
    r = '0;
    for (int i = 0; i < LOGN; i++) begin
      r[i] = a[LOGN-1-i];
    end
    return r;
  endfunction

  // Arithmetic shift (floor) followed by clamp into the signed OW range.
  function automatic logic [OW-1:0] scale_sat(input logic signed [IW-1:0] din);
    logic signed [WW-1:0] ext;
    logic signed [WW-1:0] shr;
    logic [OW-1:0]        res;
    ext = {{(WW-IW){din[IW-1]}}, din};
    shr = ext >>> SHIFT;
    if (shr > SAT_MAX) begin
      res = SAT_MAX[OW-1:0];
    end else if (shr < SAT_MIN) begin
      res = SAT_MIN[OW-1:0];
    end else begin
      res = shr[OW-1:0];
    end
    return res;
  endfunction

  assign cap_addr = (BITREV != 0) ? bit_reverse(index_q) : index_q;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    ovr_d   = ovr_q;
    start_d = 1'b0;
    valid_d = 1'b0;
    dore_d  = dore_q;
    doim_d  = doim_q;
    we_d    = 1'b0;
    waddr_d = '0;
    raddr_d = '0;

    if (ED) begin
      unique case (state_q)
        S_IDLE: begin
          if (RDY) begin
            we_d    = 1'b1;
            waddr_d = '0;
            index_d = LOGN'(1);
            state_d = S_CAPT;
          end
        end

        S_CAPT: begin
          we_d = 1'b1;
          if (RDY) begin
            // A new frame header mid-capture wins: restart from address 0.
            waddr_d = '0;
            index_d = LOGN'(1);
            ovr_d   = 1'b1;
          end else begin
            waddr_d = cap_addr;
            index_d = index_q + LOGN'(1);
            if (index_q == LAST) begin
              state_d = S_FULL;
            end
          end
        end

        S_FULL: begin
          if (RDY) begin
            ovr_d = 1'b1;
          end
          if (RD_REQ) begin
            raddr_d = '0;
            dore_d  = scale_sat(mem_re_q[raddr_d]);
            doim_d  = scale_sat(mem_im_q[raddr_d]);
            start_d = 1'b1;
            valid_d = 1'b1;
            index_d = '0;
            state_d = S_PLAY;
          end
        end

        S_PLAY: begin
          if (RDY) begin
            ovr_d = 1'b1;
          end
          // index_q is the beat currently on the outputs; the last one retires here.
          if (index_q == LAST) begin
            index_d = '0;
            state_d = S_IDLE;
          end else begin
            raddr_d = index_q + LOGN'(1);
            dore_d  = scale_sat(mem_re_q[raddr_d]);
            doim_d  = scale_sat(mem_im_q[raddr_d]);
            valid_d = 1'b1;
            index_d = raddr_d;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      index_q <= '0;
      ovr_q   <= 1'b0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      dore_q  <= '0;
      doim_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      ovr_q   <= ovr_d;
      start_q <= start_d;
      valid_q <= valid_d;
      dore_q  <= dore_d;
      doim_q  <= doim_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (we_d && !RST) begin
      mem_re_q[waddr_d] <= DIReal;
      mem_im_q[waddr_d] <= DIImag;
    end
  end

  assign FULL   = (state_q == S_FULL);
  assign START  = start_q;
  assign VALID  = valid_q;
  assign DOReal = dore_q;
  assign DOImag = doim_q;
  assign OVR    = ovr_q;

endmodule

// File: tb/tb_fft16_frame_capture.sv
// Directed bench for fft16_frame_capture: a vector table for the plain capture/replay
// loop, plus hand-written sequences for gaps, restarts, reset and saturation/bit-reversal.
module tb_fft16_frame_capture;

  logic        clk = 1'b0;
  logic        rst, ed, rdy, rd_req;
  logic [35:0] dre, dim;
  logic        full, start, valid, ovr;
  logic [31:0] dor, doi;

  logic        rdy2, rd_req2;
  logic [35:0] dre2, dim2;
  logic        full2, start2, valid2, ovr2;
  logic [31:0] dor2, doi2;

  always #5 clk = ~clk;

  fft16_frame_capture dut (
    .CLK(clk), .RST(rst), .ED(ed), .RDY(rdy), .DIReal(dre), .DIImag(dim),
    .RD_REQ(rd_req), .FULL(full), .START(start), .VALID(valid),
    .DOReal(dor), .DOImag(doi), .OVR(ovr)
  );

  fft16_frame_capture #(.SHIFT(0), .BITREV(1)) dut2 (
    .CLK(clk), .RST(rst), .ED(ed), .RDY(rdy2), .DIReal(dre2), .DIImag(dim2),
    .RD_REQ(rd_req2), .FULL(full2), .START(start2), .VALID(valid2),
    .DOReal(dor2), .DOImag(doi2), .OVR(ovr2)
  );

  typedef struct {
    logic        ed;
    logic        rdy;
    logic        rd_req;
    logic [35:0] dre;
    logic [35:0] dim;
    logic        e_full;
    logic        e_start;
    logic        e_valid;
    logic [31:0] e_re;
    logic [31:0] e_im;
    logic        e_ovr;
  } vec_t;

  vec_t tv[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [35:0] s36(input longint v);
    return v[35:0];
  endfunction

  function automatic logic [31:0] s32(input int v);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic ef, input logic es, input logic ev,
                     input logic [31:0] er, input logic [31:0] ei, input logic eo);
    n_vec++;
    if ({full, start, valid, dor, doi, ovr} !== {ef, es, ev, er, ei, eo}) begin
      n_bad++;
      $display("FAIL %s @%0t: got full=%b start=%b valid=%b re=%h im=%h ovr=%b, want full=%b start=%b valid=%b re=%h im=%h ovr=%b",
               nm, $time, full, start, valid, dor, doi, ovr, ef, es, ev, er, ei, eo);
    end
  endtask

  task automatic chk2(input string nm, input logic ef, input logic es, input logic ev,
                      input logic [31:0] er, input logic [31:0] ei, input logic eo);
    n_vec++;
    if ({full2, start2, valid2, dor2, doi2, ovr2} !== {ef, es, ev, er, ei, eo}) begin
      n_bad++;
      $display("FAIL %s @%0t: got full=%b start=%b valid=%b re=%h im=%h ovr=%b, want full=%b start=%b valid=%b re=%h im=%h ovr=%b",
               nm, $time, full2, start2, valid2, dor2, doi2, ovr2, ef, es, ev, er, ei, eo);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [35:0] in_re [16];
    logic [35:0] in_im [16];
    logic [31:0] x_re  [16];
    logic [31:0] x_im  [16];
    int          ord   [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    int          cyc;
    int          beat;
    int          k;
    logic        e;
    logic        done;

    rst = 1'b1; ed = 1'b1; rdy = 1'b0; rd_req = 1'b0; dre = '0; dim = '0;
    rdy2 = 1'b0; rd_req2 = 1'b0; dre2 = '0; dim2 = '0;

    // Reset held three cycles with RDY / RD_REQ toggling
    for (int i = 0; i < 3; i++) begin
      rdy    = (i % 2 == 0);
      rd_req = (i % 2 == 1);
      step();
      chk("reset", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    end
    chk2("reset2", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    rst = 1'b0; rdy = 1'b0; rd_req = 1'b0;

    // Plain loop: capture 16*k / -16*k, replay (k,-k)
    for (int i = 0; i < 16; i++)
      tv.push_back('{1'b1, (i == 0), 1'b0, s36(16 * i), s36(-16 * i),
                     (i == 15), 1'b0, 1'b0, 32'd0, 32'd0, 1'b0});
    tv.push_back('{1'b1, 1'b0, 1'b0, 36'd0, 36'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0});
    tv.push_back('{1'b1, 1'b0, 1'b1, 36'd0, 36'd0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 1'b0});
    for (int i = 1; i < 16; i++)
      tv.push_back('{1'b1, 1'b0, 1'b0, 36'd0, 36'd0, 1'b0, 1'b0, 1'b1, s32(i), s32(-i), 1'b0});
    for (int i = 0; i < 2; i++)
      tv.push_back('{1'b1, 1'b0, 1'b0, 36'd0, 36'd0, 1'b0, 1'b0, 1'b0, s32(15), s32(-15), 1'b0});

    foreach (tv[i]) begin
      ed = tv[i].ed; rdy = tv[i].rdy; rd_req = tv[i].rd_req; dre = tv[i].dre; dim = tv[i].dim;
      step();
      chk("loop", tv[i].e_full, tv[i].e_start, tv[i].e_valid, tv[i].e_re, tv[i].e_im, tv[i].e_ovr);
    end
    rdy = 1'b0; rd_req = 1'b0;

    // ED low every third cycle during capture and replay
    cyc = 0; k = 0;
    for (int n = 0; n < 40 && k < 16; n++) begin
      ed = (cyc % 3 != 2);
      e  = ed;
      if (e) begin
        rdy = (k == 0); dre = s36(16 * (k + 20)); dim = s36(-16 * (k + 20));
      end else begin
        rdy = 1'b0; dre = s36(12345); dim = s36(-777);
      end
      step();
      cyc++;
      if (e) k++;
      chk("gap_capt", (k == 16), 1'b0, 1'b0, s32(15), s32(-15), 1'b0);
    end
    rdy = 1'b0; ed = 1'b1; rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    chk("gap_start", 1'b0, 1'b1, 1'b1, s32(20), s32(-20), 1'b0);
    beat = 0; done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      ed = (cyc % 3 != 2);
      e  = ed;
      cyc++;
      step();
      if (e) begin
        if (beat == 15) begin
          done = 1'b1;
          chk("gap_end", 1'b0, 1'b0, 1'b0, s32(35), s32(-35), 1'b0);
        end else begin
          beat++;
          chk("gap_beat", 1'b0, 1'b0, 1'b1, s32(beat + 20), s32(-(beat + 20)), 1'b0);
        end
      end else begin
        chk("gap_hold", 1'b0, 1'b0, 1'b0, s32(beat + 20), s32(-(beat + 20)), 1'b0);
      end
    end
    ed = 1'b1;

    // RDY again at capture index 7 restarts; RDY in FULL / PLAY is dropped
    for (int i = 0; i < 7; i++) begin
      rdy = (i == 0); dre = s36(16 * (i + 40)); dim = s36(-16 * (i + 40));
      step();
      chk("restart_a", 1'b0, 1'b0, 1'b0, s32(35), s32(-35), 1'b0);
    end
    for (int j = 0; j < 16; j++) begin
      rdy = (j == 0); dre = s36(16 * (j + 60)); dim = s36(-16 * (j + 60));
      step();
      chk("restart_b", (j == 15), 1'b0, 1'b0, s32(35), s32(-35), 1'b1);
    end
    rdy = 1'b1; dre = s36(16 * 999); dim = s36(16 * 999);
    step();
    rdy = 1'b0;
    chk("rdy_in_full", 1'b1, 1'b0, 1'b0, s32(35), s32(-35), 1'b1);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    chk("restart_start", 1'b0, 1'b1, 1'b1, s32(60), s32(-60), 1'b1);
    for (int b = 1; b <= 16; b++) begin
      rdy = (b == 8 || b == 16); dre = s36(16 * 500); dim = s36(16 * 500);
      step();
      rdy = 1'b0;
      if (b < 16) chk("restart_beat", 1'b0, 1'b0, 1'b1, s32(b + 60), s32(-(b + 60)), 1'b1);
      else        chk("restart_end", 1'b0, 1'b0, 1'b0, s32(75), s32(-75), 1'b1);
    end
    for (int n = 0; n < 16; n++) begin
      dre = s36(16 * n); dim = s36(16 * n);
      step();
      chk("no_capture", 1'b0, 1'b0, 1'b0, s32(75), s32(-75), 1'b1);
    end

    // Reset at replay beat 5, then a fresh frame with floor-rounding on the imag part
    for (int i = 0; i < 16; i++) begin
      rdy = (i == 0); dre = s36(16 * (i + 80)); dim = s36(-16 * (i + 80));
      step();
      chk("frame_d", (i == 15), 1'b0, 1'b0, s32(75), s32(-75), 1'b1);
    end
    rdy = 1'b0; rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    chk("d_start", 1'b0, 1'b1, 1'b1, s32(80), s32(-80), 1'b1);
    for (int b = 1; b <= 5; b++) begin
      step();
      chk("d_beat", 1'b0, 1'b0, 1'b1, s32(b + 80), s32(-(b + 80)), 1'b1);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_play", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    step();
    chk("rst_idle", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      rdy = (i == 0); dre = s36(16 * (i - 8)); dim = s36(16 * i - 3);
      step();
      chk("frame_c", (i == 15), 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    end
    rdy = 1'b1; dre = s36(4096); dim = s36(4096);
    step();
    rdy = 1'b0;
    chk("rdy_full_ovr", 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    chk("c_start", 1'b0, 1'b1, 1'b1, s32(-8), s32(-1), 1'b1);
    for (int b = 1; b < 16; b++) begin
      step();
      chk("c_beat", 1'b0, 1'b0, 1'b1, s32(b - 8), s32(b - 1), 1'b1);
    end
    step();
    chk("c_end", 1'b0, 1'b0, 1'b0, s32(7), s32(14), 1'b1);

    // SHIFT=0 saturation and bit-reversed capture addressing on the second instance
    for (int i = 0; i < 16; i++) begin
      in_re[i] = s36(1000 * i); x_re[i] = s32(1000 * i);
      in_im[i] = s36(-i);       x_im[i] = s32(-i);
    end
    in_re[0] = 36'h4_0000_0000; x_re[0] = 32'h7FFF_FFFF;
    in_im[0] = 36'hC_0000_0000; x_im[0] = 32'h8000_0000;
    in_re[1] = 36'hC_0000_0000; x_re[1] = 32'h8000_0000;
    in_im[1] = 36'h4_0000_0000; x_im[1] = 32'h7FFF_FFFF;
    in_re[2] = 36'h0_7FFF_FFFF; x_re[2] = 32'h7FFF_FFFF;
    in_re[3] = 36'hF_8000_0000; x_re[3] = 32'h8000_0000;
    in_re[4] = 36'h0_8000_0000; x_re[4] = 32'h7FFF_FFFF;
    in_re[5] = 36'hF_7FFF_FFFF; x_re[5] = 32'h8000_0000;
    for (int i = 0; i < 16; i++) begin
      rdy2 = (i == 0); dre2 = in_re[i]; dim2 = in_im[i];
      step();
      chk2("d2_capt", (i == 15), 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    end
    rdy2 = 1'b0; rd_req2 = 1'b1;
    step();
    rd_req2 = 1'b0;
    chk2("d2_start", 1'b0, 1'b1, 1'b1, x_re[ord[0]], x_im[ord[0]], 1'b0);
    for (int j = 1; j < 16; j++) begin
      step();
      chk2("d2_beat", 1'b0, 1'b0, 1'b1, x_re[ord[j]], x_im[ord[j]], 1'b0);
    end
    step();
    chk2("d2_end", 1'b0, 1'b0, 1'b0, x_re[15], x_im[15], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
